// File: rtl/elastic_pipe.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, synchronous
// flush and an optional one-entry input skid buffer.
module elastic_pipe #(
  parameter int            _W      = 32,
  parameter int            DEPTH   = 2,
  parameter int            SKID    = 0,
  parameter logic [_W-1:0] RST_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [_W-1:0]                   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [_W-1:0]                   out_data,
  output logic [$clog2(DEPTH+SKID+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + SKID + 1);

  logic [DEPTH-1:0] stage_v;
  logic [_W-1:0]    stage_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_v;
  logic [_W-1:0]    up_d [DEPTH];
  logic             skid_v;
  logic             src_v;
  logic [_W-1:0]    src_d;
  logic             accept;

  // A stage may load when it or any stage downstream is empty, or the output
  // drains; an empty slot anywhere below lets everything above it slide down.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~stage_v[i];
      adv[i] = room;
    end
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = src_v;
    up_d[0] = src_d;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = stage_v[i-1];
      up_d[i] = stage_d[i-1];
    end
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v <= '0;
      for (int i = 0; i < DEPTH; i++) stage_d[i] <= RST_VAL;
    end else if (flush) begin
      stage_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          stage_v[i] <= up_v[i];
          if (up_v[i]) stage_d[i] <= up_d[i];
        end
      end
    end
  end

  if (SKID != 0) begin : g_skid
    logic [_W-1:0] skid_d;
    logic          rdy_q;

    // The skid entry catches a beat that stage 0 cannot take, and always
    // feeds stage 0 ahead of new input so ordering holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_v <= 1'b0;
        skid_d <= RST_VAL;
        rdy_q  <= 1'b0;
      end else if (flush) begin
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end else begin
        skid_v <= (skid_v | accept) & ~adv[0];
        rdy_q  <= ~((skid_v | accept) & ~adv[0]);
        if (accept & ~adv[0]) skid_d <= in_data;
      end
    end

    assign in_ready = rdy_q & ~flush;
    assign src_v    = skid_v | accept;
    assign src_d    = skid_v ? skid_d : in_data;
  end else begin : g_noskid
    assign skid_v   = 1'b0;
    assign in_ready = adv[0] & ~flush;
    assign src_v    = accept;
    assign src_d    = in_data;
  end

  always_comb begin
    logic [CW-1:0] sum;
    sum = CW'(skid_v);
    for (int i = 0; i < DEPTH; i++) sum = sum + CW'(stage_v[i]);
    count = flush ? '0 : sum;
  end

  assign out_valid = stage_v[DEPTH-1] & ~flush;
  assign out_data  = stage_d[DEPTH-1];

endmodule
